// File: rtl/multi_timer.sv
// Memory-mapped bank of NCH up-counting timer channels sharing one prescaler.
// Each channel has CNT/LIM/CTL registers on a tri-state data bus and raises IRQ when RDY and IE are both set.

module multi_timer_ch #(
  parameter int BITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic            wr_cnt_i,
  input  logic            wr_lim_i,
  input  logic            wr_ctl_i,
  input  logic [BITS-1:0] wdata_i,
  output logic [BITS-1:0] cnt_o,
  output logic [BITS-1:0] lim_o,
  output logic [BITS-1:0] ctl_o,
  output logic            irq_o
);
  logic [BITS-1:0] cnt_q, cnt_d, lim_q, lim_d, cnt_inc;
  logic rdy_q, rdy_d, ovr_q, ovr_d, ie_q, ie_d, en_q, en_d, os_q, os_d;
  logic match;

  assign cnt_inc = cnt_q + BITS'(1);
  // A CNT write on a tick swallows that tick, including any match it would produce.
  assign match   = tick_i && en_q && !wr_cnt_i && (cnt_inc == lim_q);

  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    rdy_d = rdy_q;
    ovr_d = ovr_q;
    ie_d  = ie_q;
    en_d  = en_q;
    os_d  = os_q;
    if (wr_cnt_i)              cnt_d = wdata_i;
    else if (tick_i && en_q)   cnt_d = match ? '0 : cnt_inc;
    if (wr_lim_i)              lim_d = wdata_i;
    if (match && os_q)         en_d  = 1'b0;
    if (wr_ctl_i) begin
      ie_d  = wdata_i[4];
      en_d  = wdata_i[5];
      os_d  = wdata_i[6];
      rdy_d = rdy_q & wdata_i[0];
      ovr_d = ovr_q & wdata_i[2];
    end
    // Hardware status set beats a software write-0 clear.
    if (match) begin
      rdy_d = 1'b1;
      if (rdy_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lim_q <= '0;
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
      ie_q  <= 1'b0;
      en_q  <= 1'b0;
      os_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
      ie_q  <= ie_d;
      en_q  <= en_d;
      os_q  <= os_d;
    end
  end

  always_comb begin
    ctl_o    = '0;
    ctl_o[0] = rdy_q;
    ctl_o[2] = ovr_q;
    ctl_o[4] = ie_q;
    ctl_o[5] = en_q;
    ctl_o[6] = os_q;
  end

  assign cnt_o = cnt_q;
  assign lim_o = lim_q;
  assign irq_o = rdy_q & ie_q;
endmodule

module multi_timer #(
  parameter int          BITS = 32,
  parameter logic [31:0] BASE = 32'hF0000020,
  parameter int          DIV  = 1000,
  parameter int          NCH  = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic            FLUSH,
  output logic            IRQ,
  output logic [7:0]      DEBUG
);
  localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BITS-1:0] BASE_W = BITS'(BASE);

  logic [PW-1:0] psc_q, psc_d;
  logic          tick;

  logic [NCH-1:0]           sel_cnt, sel_lim, sel_ctl, irq_ch;
  logic [NCH-1:0][BITS-1:0] cnt, lim, ctl;
  logic [BITS-1:0]          wdata, rdata;
  logic                     rd_en;

  assign tick  = (psc_q == PW'(DIV - 1));
  assign psc_d = tick ? '0 : psc_q + PW'(1);

  always_ff @(posedge CLK) begin
    if (RESET) psc_q <= '0;
    else       psc_q <= psc_d;
  end

  assign wdata = DBUS;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    localparam logic [BITS-1:0] A_CNT = BASE_W + BITS'(16 * n);
    assign sel_cnt[n] = !FLUSH && (ABUS == A_CNT);
    assign sel_lim[n] = !FLUSH && (ABUS == A_CNT + BITS'(4));
    assign sel_ctl[n] = !FLUSH && (ABUS == A_CNT + BITS'(8));

    multi_timer_ch #(.BITS(BITS)) u_ch (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .tick_i   (tick),
      .wr_cnt_i (sel_cnt[n] && WE),
      .wr_lim_i (sel_lim[n] && WE),
      .wr_ctl_i (sel_ctl[n] && WE),
      .wdata_i  (wdata),
      .cnt_o    (cnt[n]),
      .lim_o    (lim[n]),
      .ctl_o    (ctl[n]),
      .irq_o    (irq_ch[n])
    );
  end

  // At most one select is live, so an OR-mux is enough.
  always_comb begin
    rdata = '0;
    for (int n = 0; n < NCH; n++) begin
      if (sel_cnt[n]) rdata = rdata | cnt[n];
      if (sel_lim[n]) rdata = rdata | lim[n];
      if (sel_ctl[n]) rdata = rdata | ctl[n];
    end
  end

  assign rd_en = !WE && (|{sel_cnt, sel_lim, sel_ctl});
  assign DBUS  = rd_en ? rdata : 'z;

  assign IRQ   = |irq_ch;
  assign DEBUG = {cnt[0][5:0], ctl[0][2], ctl[0][0]};
endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: vector table, directed corner sequences and random bus traffic against a cycle model.
module tb_multi_timer;
  localparam int          NCH  = 4;
  localparam int          DIV  = 2;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] HZ   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] abus = '0;
  logic        we = 1'b0;
  logic        flush = 1'b0;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_dat = '0;
  logic        irq;
  logic [7:0]  dbg;
  tri1  [31:0] dbus;

  assign dbus = tb_oe ? tb_dat : 'z;

  multi_timer #(.BITS(32), .BASE(BASE), .DIV(DIV), .NCH(NCH)) dut (
    .CLK(clk), .RESET(rst), .ABUS(abus), .DBUS(dbus),
    .WE(we), .FLUSH(flush), .IRQ(irq), .DEBUG(dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain per-channel state, tick derived from cycles since reset.
  logic [31:0] m_cnt[NCH];
  logic [31:0] m_lim[NCH];
  bit          m_rdy[NCH], m_ovr[NCH], m_ie[NCH], m_en[NCH], m_os[NCH];
  int          m_cyc = 0;
  bit          m_valid = 1'b0;

  function automatic bit m_tick();
    return (m_cyc % DIV) == DIV - 1;
  endfunction

  function automatic logic [31:0] m_ctl(input int c);
    return 32'(m_rdy[c]) + 32'(m_ovr[c]) * 4 + 32'(m_ie[c]) * 16 + 32'(m_en[c]) * 32 + 32'(m_os[c]) * 64;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input bit fl);
    longint off;
    if (fl) return HZ;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 16 * NCH) return HZ;
    case (off % 16)
      0:       return m_cnt[off / 16];
      4:       return m_lim[off / 16];
      8:       return m_ctl(int'(off / 16));
      default: return HZ;
    endcase
  endfunction

  function automatic bit m_irq();
    bit r = 1'b0;
    for (int c = 0; c < NCH; c++) r = r | (m_rdy[c] & m_ie[c]);
    return r;
  endfunction

  function automatic logic [7:0] m_dbg();
    return {m_cnt[0][5:0], m_ovr[0], m_rdy[0]};
  endfunction

  task automatic m_step(input bit r, input logic [31:0] a, input bit w, input bit fl, input logic [31:0] d);
    longint off;
    bit tk, match, old_rdy, old_os, wc, wl, wt;
    logic [31:0] nx;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_lim[c] = 0;
        m_rdy[c] = 0; m_ovr[c] = 0; m_ie[c] = 0; m_en[c] = 0; m_os[c] = 0;
      end
      m_cyc = 0;
      m_valid = 1'b1;
      return;
    end
    tk  = m_tick();
    off = longint'(a) - longint'(BASE);
    for (int c = 0; c < NCH; c++) begin
      wc = w && !fl && off == 16 * c;
      wl = w && !fl && off == 16 * c + 4;
      wt = w && !fl && off == 16 * c + 8;
      nx = m_cnt[c] + 32'd1;
      match   = tk && m_en[c] && !wc && nx == m_lim[c];
      old_rdy = m_rdy[c];
      old_os  = m_os[c];
      if (wc) m_cnt[c] = d;
      else if (tk && m_en[c]) m_cnt[c] = match ? 32'd0 : nx;
      if (wl) m_lim[c] = d;
      if (wt) begin
        m_ie[c] = d[4]; m_en[c] = d[5]; m_os[c] = d[6];
        m_rdy[c] = m_rdy[c] & d[0];
        m_ovr[c] = m_ovr[c] & d[2];
      end
      if (match) begin
        m_rdy[c] = 1'b1;
        if (old_rdy) m_ovr[c] = 1'b1;
        if (old_os && !wt) m_en[c] = 1'b0;
      end
    end
    m_cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive after negedge, sample mid-cycle, then advance the model at the edge.
  task automatic bus(input bit r, input logic [31:0] a, input bit w, input bit fl, input logic [31:0] d,
                     output logic [31:0] rd, output logic ir, output logic [7:0] dg);
    @(negedge clk);
    rst = r; abus = a; we = w; flush = fl; tb_dat = d; tb_oe = w;
    #1;
    rd = dbus; ir = irq; dg = dbg;
    if (m_valid) begin
      chk($sformatf("bus_irq@%h", a), {31'b0, ir}, {31'b0, m_irq()});
      chk($sformatf("bus_dbg@%h", a), {24'b0, dg}, {24'b0, m_dbg()});
      if (!w) chk($sformatf("bus_rd@%h", a), rd, m_read(a, fl));
    end
    @(posedge clk);
    m_step(r, a, w, fl, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ir; logic [7:0] dg;
    bus(1'b0, a, 1'b1, 1'b0, d, rd, ir, dg);
  endtask

  task automatic rdc(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic ir; logic [7:0] dg;
    bus(1'b0, a, 1'b0, 1'b0, 32'd0, rd, ir, dg);
    chk(nm, rd, exp);
  endtask

  task automatic idle(input int n);
    logic [31:0] rd; logic ir; logic [7:0] dg;
    for (int i = 0; i < n; i++) bus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, rd, ir, dg);
  endtask

  task automatic align_tick();
    for (int i = 0; i < DIV && !m_tick(); i++) idle(1);
  endtask

  task automatic align_notick();
    for (int i = 0; i < DIV && m_tick(); i++) idle(1);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          w;
    bit          fl;
    logic [31:0] wd;
    bit          ck;
    logic [31:0] rd;
    bit          irq;
    logic [7:0]  dbg;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic [31:0] a, input bit w, input bit fl, input logic [31:0] wd,
                              input bit ck, input logic [31:0] rd, input bit ir, input logic [7:0] dg);
    vec_t v;
    v.addr = a; v.w = w; v.fl = fl; v.wd = wd; v.ck = ck; v.rd = rd; v.irq = ir; v.dbg = dg;
    return v;
  endfunction

  initial begin
    logic [31:0] rd; logic ir; logic [7:0] dg;
    logic [31:0] a, d;
    int ch, rg;
    bit w, fl, r;

    // Channel 0, LIM=3, periodic with IE; rows start on the cycle right after reset (prescaler 0).
    tbl[0]  = mk(32'h104, 1, 0, 32'd3,    0, 32'h0,  0, 8'h00);
    tbl[1]  = mk(32'h108, 1, 0, 32'h30,   0, 32'h0,  0, 8'h00);
    tbl[2]  = mk(32'h100, 0, 0, 32'h0,    1, 32'd0,  0, 8'h00);
    tbl[3]  = mk(32'h100, 0, 0, 32'h0,    1, 32'd0,  0, 8'h00);
    tbl[4]  = mk(32'h100, 0, 0, 32'h0,    1, 32'd1,  0, 8'h04);
    tbl[5]  = mk(32'h100, 0, 0, 32'h0,    1, 32'd1,  0, 8'h04);
    tbl[6]  = mk(32'h100, 0, 0, 32'h0,    1, 32'd2,  0, 8'h08);
    tbl[7]  = mk(32'h100, 0, 0, 32'h0,    1, 32'd2,  0, 8'h08);
    tbl[8]  = mk(32'h108, 0, 0, 32'h0,    1, 32'h31, 1, 8'h01);
    tbl[9]  = mk(32'h108, 1, 0, 32'h30,   0, 32'h0,  1, 8'h01);
    tbl[10] = mk(32'h108, 0, 0, 32'h0,    1, 32'h30, 0, 8'h04);
    tbl[11] = mk(32'h10C, 0, 0, 32'h0,    1, HZ,     0, 8'h04);
    tbl[12] = mk(32'h140, 0, 0, 32'h0,    1, HZ,     0, 8'h08);
    tbl[13] = mk(32'h100, 0, 1, 32'h0,    1, HZ,     0, 8'h08);
    tbl[14] = mk(32'h104, 1, 1, 32'd7,    0, 32'h0,  1, 8'h01);
    tbl[15] = mk(32'h104, 0, 0, 32'h0,    1, 32'd3,  1, 8'h01);
    tbl[16] = mk(32'h10C, 1, 0, 32'hFFFF, 0, 32'h0,  1, 8'h05);
    tbl[17] = mk(32'h108, 0, 0, 32'h0,    1, 32'h31, 1, 8'h05);

    bus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, rd, ir, dg);
    bus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, rd, ir, dg);
    chk("reset_irq", {31'b0, ir}, 32'd0);
    chk("reset_dbg", {24'b0, dg}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      bus(1'b0, tbl[i].addr, tbl[i].w, tbl[i].fl, tbl[i].wd, rd, ir, dg);
      if (tbl[i].ck) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_irq", i), {31'b0, ir}, {31'b0, tbl[i].irq});
      chk($sformatf("tbl%0d_dbg", i), {24'b0, dg}, {24'b0, tbl[i].dbg});
    end

    // One-shot channel 1: stops after first match, no overflow.
    wr(32'h114, 32'd2); wr(32'h118, 32'h70);
    idle(10);
    rdc("oneshot_ctl", 32'h118, 32'h51);
    idle(4);
    rdc("oneshot_cnt", 32'h110, 32'd0);

    // Periodic channel 2 never acknowledged: overflow latches.
    wr(32'h124, 32'd2); wr(32'h128, 32'h30);
    idle(12);
    rdc("ovr_ctl", 32'h128, 32'h35);

    // CNT write on a tick wins.
    wr(32'h134, 32'h100); wr(32'h138, 32'h20);
    align_tick();
    wr(32'h130, 32'h55);
    rdc("cntwr_tick", 32'h130, 32'h55);

    // CTL write-0 on the match tick: RDY still sets.
    wr(32'h134, 32'hFF);
    align_notick();
    wr(32'h130, 32'hFE);
    align_tick();
    wr(32'h138, 32'h20);
    rdc("ctlclr_match", 32'h138, 32'h21);
    rdc("ctlclr_cnt", 32'h130, 32'd0);

    // Written EN beats the one-shot auto-clear; OVR sets since RDY was pending.
    align_notick();
    wr(32'h130, 32'hF0);
    wr(32'h138, 32'h61);
    align_notick();
    wr(32'h130, 32'hFE);
    align_tick();
    wr(32'h138, 32'h60);
    rdc("en_wins", 32'h138, 32'h65);

    // LIM=0 on channel 0: passes through all ones, matches on the wrap.
    wr(32'h104, 32'd0); wr(32'h108, 32'h20);
    align_notick();
    wr(32'h100, 32'hFFFF_FFFE);
    idle(1);
    rdc("lim0_pre", 32'h108, 32'h20);
    idle(1);
    rdc("lim0_rdy", 32'h108, 32'h21);
    rdc("lim0_cnt", 32'h100, 32'd0);

    // Reset pulse with all channels running.
    for (int c = 0; c < NCH; c++) begin
      wr(BASE + 32'(16 * c) + 32'd4, 32'd5);
      wr(BASE + 32'(16 * c) + 32'd8, 32'h30);
    end
    idle(5);
    bus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, rd, ir, dg);
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 3; k++)
        rdc($sformatf("rst_reg%0d_%0d", c, k), BASE + 32'(16 * c + 4 * k), 32'd0);
    idle(6);
    bus(1'b0, BASE, 1'b0, 1'b0, 32'd0, rd, ir, dg);
    chk("rst_cnt_idle", rd, 32'd0);
    chk("rst_irq", {31'b0, ir}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ch = $urandom_range(0, NCH - 1);
      rg = $urandom_range(0, 3);
      a  = BASE + 32'(16 * ch + 4 * rg);
      if ($urandom_range(0, 19) == 0) a = BASE + 32'(16 * NCH) + 32'(4 * $urandom_range(0, 3));
      w  = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 199) == 0);
      case (rg)
        0:       d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 4));
        1:       d = 32'($urandom_range(0, 5));
        default: d = $urandom | (($urandom_range(0, 1) == 0) ? 32'h20 : 32'h0);
      endcase
      bus(r, a, w, fl, d, rd, ir, dg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
